// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - frame timing derivations and FSM encoding for servo_pwm_mc
package servo_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } state_e;

  function automatic int period_f(input int clk_freq, input int pwm_freq);
    return clk_freq / pwm_freq;
  endfunction

  function automatic int min_cyc_f(input int clk_freq, input int min_us);
    return min_us * (clk_freq / 1_000_000);
  endfunction

  function automatic int cyc_per_deg_f(input int clk_freq, input int min_us,
                                       input int max_us, input int max_angle);
    return ((max_us - min_us) * (clk_freq / 1_000_000)) / max_angle;
  endfunction

endpackage

// File: rtl/servo_pwm_mc_counter.sv
// rtl/servo_pwm_mc_counter.sv - free-running 0..C_MAX-1 frame counter with wrap flag
module servo_pwm_mc_counter #(
  parameter int C_MAX = 20000,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n_a,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q, count_d;

  assign wrap_o  = (count_q == W'(C_MAX - 1));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q + 1'b1;
    if (wrap_o) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/servo_pwm_mc.sv
// rtl/servo_pwm_mc.sv - multi-channel servo PWM with per-frame slew-limited angle updates
module servo_pwm_mc
  import servo_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int PWM_FREQ     = 50,
  parameter int N_CH         = 4,
  parameter int ANGLE_W      = 8,
  parameter int MAX_ANGLE    = 180,
  parameter int MIN_PULSE_US = 1000,
  parameter int MAX_PULSE_US = 2000,
  parameter int STEP         = 2,
  parameter int RESET_ANGLE  = 90
) (
  input  logic                                     clk,
  input  logic                                     rst_n_a,
  input  logic                                     wr_valid,
  output logic                                     wr_ready,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch,
  input  logic [ANGLE_W-1:0]                       wr_angle,
  output logic [N_CH-1:0]                          pwm_out,
  output logic [N_CH-1:0]                          busy,
  output logic                                     frame_tick
);

  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PERIOD      = period_f(CLK_FREQ, PWM_FREQ);
  localparam int MIN_CYC     = min_cyc_f(CLK_FREQ, MIN_PULSE_US);
  localparam int CYC_PER_DEG = cyc_per_deg_f(CLK_FREQ, MIN_PULSE_US, MAX_PULSE_US, MAX_ANGLE);
  localparam int W           = $clog2(PERIOD) + 1;

  localparam logic [ANGLE_W-1:0] MAX_A   = ANGLE_W'(MAX_ANGLE);
  localparam logic [ANGLE_W-1:0] RESET_A = ANGLE_W'(RESET_ANGLE);
  localparam logic [ANGLE_W-1:0] STEP_A  = ANGLE_W'(STEP);

  if (MIN_CYC + MAX_ANGLE * CYC_PER_DEG >= PERIOD) begin : g_err_width
    $error("servo_pwm_mc: widest pulse does not fit inside one frame");
  end
  if (N_CH >= MIN_CYC || N_CH < 1 || N_CH > 16) begin : g_err_nch
    $error("servo_pwm_mc: N_CH out of range");
  end

  function automatic logic [W-1:0] width_f(input logic [ANGLE_W-1:0] a);
    return W'(MIN_CYC) + W'(a) * W'(CYC_PER_DEG);
  endfunction

  function automatic logic [ANGLE_W-1:0] step_f(input logic [ANGLE_W-1:0] c,
                                                input logic [ANGLE_W-1:0] t);
    logic [ANGLE_W-1:0] nxt;
    nxt = t;
    if (STEP != 0) begin
      if (t > c && (t - c) > STEP_A)      nxt = c + STEP_A;
      else if (c > t && (c - t) > STEP_A) nxt = c - STEP_A;
    end
    return nxt;
  endfunction

  logic [W-1:0] count;
  logic         wrap;

  servo_pwm_mc_counter #(
    .C_MAX (PERIOD),
    .W     (W)
  ) u_frame_cnt (
    .clk     (clk),
    .rst_n_a (rst_n_a),
    .count_o (count),
    .wrap_o  (wrap)
  );

  state_e          state_q, state_d;
  logic [CH_W-1:0] idx_q, idx_d;
  logic            upd_en;

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // One channel per cycle, starting the cycle after count 0
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    upd_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count == '0) begin
          state_d = S_UPDATE;
          idx_d   = '0;
        end
      end
      S_UPDATE: begin
        upd_en = 1'b1;
        if (idx_q == CH_W'(N_CH - 1)) state_d = S_IDLE;
        else                          idx_d   = idx_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_ready = (state_q == S_IDLE);

  logic [ANGLE_W-1:0] target_q [N_CH];
  logic [ANGLE_W-1:0] target_d [N_CH];
  logic [ANGLE_W-1:0] cur_q    [N_CH];
  logic [ANGLE_W-1:0] cur_d    [N_CH];
  logic [W-1:0]       shadow_q [N_CH];
  logic [W-1:0]       shadow_d [N_CH];
  logic [W-1:0]       act_q    [N_CH];
  logic [W-1:0]       act_d    [N_CH];
  logic [N_CH-1:0]    pwm_q, busy_q;
  logic               tick_q;

  // Writes are only accepted outside UPDATE, so they never race a channel update
  always_comb begin
    target_d = target_q;
    cur_d    = cur_q;
    shadow_d = shadow_q;
    act_d    = act_q;
    for (int i = 0; i < N_CH; i++) begin
      if (wr_valid && wr_ready && wr_ch == CH_W'(i))
        target_d[i] = (wr_angle > MAX_A) ? MAX_A : wr_angle;
      if (upd_en && idx_q == CH_W'(i)) begin
        cur_d[i]    = step_f(cur_q[i], target_q[i]);
        shadow_d[i] = width_f(step_f(cur_q[i], target_q[i]));
      end
      if (wrap) act_d[i] = shadow_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      for (int i = 0; i < N_CH; i++) begin
        target_q[i] <= RESET_A;
        cur_q[i]    <= RESET_A;
        shadow_q[i] <= width_f(RESET_A);
        act_q[i]    <= width_f(RESET_A);
      end
      pwm_q  <= '0;
      busy_q <= '0;
      tick_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        target_q[i] <= target_d[i];
        cur_q[i]    <= cur_d[i];
        shadow_q[i] <= shadow_d[i];
        act_q[i]    <= act_d[i];
        // Pulse spans counts 0..act_w inclusive
        pwm_q[i]    <= (count <= act_q[i]);
        busy_q[i]   <= (cur_q[i] != target_q[i]);
      end
      tick_q <= (count == '0);
    end
  end

  assign pwm_out    = pwm_q;
  assign busy       = busy_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_servo_pwm_mc.sv
// tb/tb_servo_pwm_mc.sv - randomized bench for servo_pwm_mc against a frame-level reference model
module tb_servo_pwm_mc;

  localparam int P  = 4000;
  localparam int CF = 1_000_000;
  localparam int PF = 250;

  logic       clk = 1'b0;
  logic       rst_n_a = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_ch = 2'd0;
  logic [7:0] wr_angle = 8'd0;
  logic       ready_a, tick_a, ready_b, tick_b;
  logic [3:0] pwm_a, busy_a;
  logic [2:0] pwm_b, busy_b;

  always #5 clk = ~clk;

  servo_pwm_mc #(.CLK_FREQ(CF), .PWM_FREQ(PF), .N_CH(4), .STEP(2)) dut_a (
    .clk(clk), .rst_n_a(rst_n_a), .wr_valid(wr_valid), .wr_ready(ready_a),
    .wr_ch(wr_ch), .wr_angle(wr_angle), .pwm_out(pwm_a), .busy(busy_a),
    .frame_tick(tick_a));

  servo_pwm_mc #(.CLK_FREQ(CF), .PWM_FREQ(PF), .N_CH(3), .STEP(0)) dut_b (
    .clk(clk), .rst_n_a(rst_n_a), .wr_valid(wr_valid), .wr_ready(ready_b),
    .wr_ch(wr_ch), .wr_angle(wr_angle), .pwm_out(pwm_b), .busy(busy_b),
    .frame_tick(tick_b));

  int compared = 0;
  int mismatched = 0;
  bit run = 1'b0;
  int steps = 0;
  int cnt = 0;
  int tgt [2][4];
  int cur [2][4];
  int act [2][4];
  logic [3:0] exp_pwm [2];
  logic [3:0] exp_busy [2];
  logic       exp_ready [2];
  logic       exp_tick;
  int hl [2][4][16];
  int rlow [2][16];
  logic [3:0] bsnap [16];

  int mn, nxt, fr, ps;
  bit upd;
  logic [3:0] eb, ep;

  function automatic int width_of(input int a);
    return 1000 + 5 * a;
  endfunction

  function automatic int nch_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int move(input int c, input int t, input int s);
    if (s == 0) return t;
    if (t > c) return (t - c > s) ? c + s : t;
    return (c - t > s) ? c - s : t;
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cnt = 0;
    steps = 0;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        tgt[d][c] = 90;
        cur[d][c] = 90;
        act[d][c] = width_of(90);
        for (int f = 0; f < 16; f++) hl[d][c][f] = 0;
      end
      for (int f = 0; f < 16; f++) rlow[d][f] = 0;
    end
    for (int f = 0; f < 16; f++) bsnap[f] = '0;
  endtask

  // Reference model: one step per rising edge, cnt is the frame position before the edge
  always @(posedge clk) begin
    if (run) begin
      for (int d = 0; d < 2; d++) begin
        mn  = nch_of(d);
        upd = (cnt >= 1 && cnt <= mn);
        eb  = '0;
        ep  = '0;
        for (int c = 0; c < mn; c++) begin
          eb[c] = (cur[d][c] != tgt[d][c]);
          ep[c] = (cnt <= act[d][c]);
        end
        exp_busy[d] = eb;
        exp_pwm[d]  = ep;
        if (upd) cur[d][cnt-1] = move(cur[d][cnt-1], tgt[d][cnt-1], (d == 0) ? 2 : 0);
        if (cnt == P - 1)
          for (int c = 0; c < mn; c++) act[d][c] = width_of(cur[d][c]);
        if (wr_valid && !upd && int'(wr_ch) < mn)
          tgt[d][wr_ch] = (wr_angle > 8'd180) ? 180 : int'(wr_angle);
        nxt = (cnt + 1) % P;
        exp_ready[d] = !(nxt >= 1 && nxt <= mn);
      end
      exp_tick = (cnt == 0);
      cnt = (cnt + 1) % P;
      steps++;
    end
  end

  always @(negedge clk) begin
    if (run && steps > 0) begin
      check("pwm_a", int'(pwm_a), int'(exp_pwm[0]));
      check("busy_a", int'(busy_a), int'(exp_busy[0]));
      check("ready_a", int'(ready_a), int'(exp_ready[0]));
      check("tick_a", int'(tick_a), int'(exp_tick));
      check("pwm_b", int'(pwm_b), int'(exp_pwm[1][2:0]));
      check("busy_b", int'(busy_b), int'(exp_busy[1][2:0]));
      check("ready_b", int'(ready_b), int'(exp_ready[1]));
      check("tick_b", int'(tick_b), int'(exp_tick));
      fr = (steps - 1) / P;
      ps = (steps - 1) % P;
      if (fr < 16) begin
        for (int c = 0; c < 4; c++) hl[0][c][fr] += int'(pwm_a[c]);
        for (int c = 0; c < 3; c++) hl[1][c][fr] += int'(pwm_b[c]);
        rlow[0][fr] += int'(!ready_a);
        rlow[1][fr] += int'(!ready_b);
        if (ps == 100) bsnap[fr] = busy_a;
      end
    end
  end

  task automatic go(input int f, input int p, input bit rnd);
    int guard;
    guard = 0;
    while (!(steps > 0 && (steps - 1) / P == f && (steps - 1) % P == p)) begin
      if (rnd) begin
        wr_valid = ($urandom_range(0, 149) == 0) ||
                   ((steps % P) < 6 && $urandom_range(0, 1) == 1);
        wr_ch    = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd1;
        wr_angle = 8'($urandom_range(0, 255));
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
      if (guard > 60000) begin
        mismatched++;
        $display("FAIL go_timeout: got step %0d, expected frame %0d pos %0d", steps, f, p);
        $fatal(1, "position wait expired");
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wr(input int ch, input int ang);
    wr_valid = 1'b1;
    wr_ch    = 2'(ch);
    wr_angle = 8'(ang);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pwm_a"}, int'(pwm_a), 0);
    check({tag, "_busy_a"}, int'(busy_a), 0);
    check({tag, "_tick_a"}, int'(tick_a), 0);
    check({tag, "_pwm_b"}, int'(pwm_b), 0);
    check({tag, "_busy_b"}, int'(busy_b), 0);
    check({tag, "_tick_b"}, int'(tick_b), 0);
  endtask

  task automatic check_idle_frames();
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 4; c++) check($sformatf("len_a_ch%0d_f%0d", c, f), hl[0][c][f], 1451);
      for (int c = 0; c < 3; c++) check($sformatf("len_b_ch%0d_f%0d", c, f), hl[1][c][f], 1451);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst_n_a = 1'b1;
    run = 1'b1;

    go(0, 10, 1'b0);
    wr(2, 180);
    wr(0, 100);
    wr(1, 255);
    wr(3, 50);
    go(4, 0, 1'b0);
    go(7, 100, 1'b1);
    wr(0, 0);
    go(8, 500, 1'b1);

    check_idle_frames();
    check("len_b_ch2_f2", hl[1][2][2], 1901);
    check("len_b_ch1_f2_clamp", hl[1][1][2], 1901);
    check("len_b_ch0_f2", hl[1][0][2], 1501);
    check("len_b_ch0_f3", hl[1][0][3], 1501);
    check("len_b_ch1_f3", hl[1][1][3], 1901);
    check("len_a_ch1_f2_clamp", hl[0][1][2], 1461);
    check("len_a_ch2_f2", hl[0][2][2], 1461);
    check("len_a_ch3_f2", hl[0][3][2], 1441);
    for (int f = 2; f < 8; f++)
      check($sformatf("len_a_ch0_f%0d", f), hl[0][0][f], (f < 6) ? 1451 + 10 * (f - 1) : 1501);
    check("ready_low_a_f1", rlow[0][1], 4);
    check("ready_low_b_f1", rlow[1][1], 3);
    check("busy_a_f0", int'(bsnap[0]), 15);
    check("busy_a0_f4", int'(bsnap[4][0]), 1);
    check("busy_a0_f5", int'(bsnap[5][0]), 0);

    #2;
    rst_n_a = 1'b0;
    run = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    model_reset();
    rst_n_a = 1'b1;
    run = 1'b1;
    go(2, 10, 1'b1);
    check_idle_frames();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
